data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  RV32I data memory with handshake: byte-addressed, parametrised depth, configurable wait states.
//  Decodes LB/LH/LW/LBU/LHU and SB/SH/SW from funct3, and performs byte-lane steering and sign/zero extension.
//  Flags misaligned, illegal and out-of-range accesses.
//  Sits between the EX/MEM stage and the word-organised RAM array; the core stalls on req_ready/rsp_valid.
// PARAMETERS
//  ADDR_W    10   byte-address width
//  DEPTH     256  number of 32-bit words; must satisfy DEPTH*4 <= 2**ADDR_W
//  WAIT_CYC  0    extra BUSY cycles between accept and response (0..15)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       synchronous reset, active-low
//  req_valid   in   1       request present
//  req_ready   out  1       block can accept; 1 only in IDLE and rst=1
//  req_we      in   1       1=store, 0=load
//  req_funct3  in   3       RV32I funct3 of the load/store
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data (low bytes used for SB/SH)
//  rsp_valid   out  1       response strobe, exactly one cycle per accepted request
//  rsp_rdata   out  32      load result, extended; 0 for stores and errors
//  rsp_err     out  1       access fault; valid only with rsp_valid
// BEHAVIOUR
//  Reset (rst=0 at an edge):
//   - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   - req_ready=0 while rst=0. RAM contents are not reset.
//   - Reset mid-operation aborts the request; an uncommitted store is never written.
//  FSM:
//   - IDLE -> BUSY when accepted (req_valid & req_ready) and WAIT_CYC>0.
//   - IDLE -> RESP when accepted and WAIT_CYC==0.
//   - BUSY: counter counts WAIT_CYC-1..0; at 0 -> RESP.
//   - RESP: rsp_valid=1 for one cycle -> IDLE unconditionally; no back-pressure.
//  Latency and throughput:
//   - rsp_valid rises WAIT_CYC+1 edges after the accept edge.
//   - Max throughput is one request per WAIT_CYC+2 cycles.
//  Request fields are latched on the accept edge; inputs may change afterwards.
//  Commit:
//   - Array read and store write both occur on the edge entering RESP.
//   - A load sees the array state before any same-edge write.
//  funct3 decode:
//   - 000 byte; 001 half; 010 word; 100 byte unsigned (load only); 101 half unsigned (load only).
//   - Any other code, or 100/101 with req_we=1 -> err.
//  Faults (any one sets rsp_err=1, rsp_rdata=0, no write):
//   - Half with addr[0]=1.
//   - Word with addr[1:0]!=0.
//   - Illegal funct3 (as above).
//   - addr >= DEPTH*4.
//  Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
//  Store steering:
//   - SB writes lane addr[1:0] with wdata[7:0].
//   - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
//   - SW writes all 4 lanes. Unselected bytes are unchanged.
//  Load extraction:
//   - LB/LH sign-extend from bit 7/15 of the selected lane(s).
//   - LBU/LHU zero-extend. LW returns the whole word.
//  Outputs between responses:
//   - rsp_rdata and rsp_err hold their last value; only rsp_valid qualifies them.
// TESTING
//  1) WAIT_CYC=0: SW 0xDEADBEEF @0x010, then LW @0x010.
//     -> each rsp_valid 1 cycle after accept; rdata=0xDEADBEEF, err=0.
//  2) SB 0x80 @0x013, then LB @0x013 and LBU @0x013.
//     -> 0xFFFFFF80 and 0x00000080; LW @0x010 -> 0x80ADBEEF.
//  3) SH @0x011 and LW @0x012.
//     -> err=1, rdata=0; memory word @0x010 unchanged; funct3=011 -> err=1.
//  4) DEPTH=256: LW @0x400.
//     -> err=1. WAIT_CYC=3: req_ready low for 4 cycles after accept; rsp_valid on the 4th edge.
//  5) WAIT_CYC=3: SW 0x12345678 @0x020 accepted; rst=0 during BUSY.
//     -> rsp_valid never rises; after reset, LW @0x020 returns the prior contents.
//  6) Hold req_valid=1 continuously; change req_wdata during BUSY.
//     -> one response per WAIT_CYC+2 cycles; stored value equals the data latched at accept.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I data memory with a valid/ready request port, optional
// wait states, byte-lane steering, load sign/zero extension and fault flagging.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);
    localparam logic [CNT_W-1:0]   CNT_INIT   = (WAIT_CYC == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;

    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic              cur_we;
    logic [2:0]        cur_f3;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;

    logic              accept_c;
    logic              commit_c;
    logic              err_c;
    logic [IDX_W-1:0]  idx_c;
    logic [3:0]        be_c;
    logic [31:0]       wd_c;
    logic [31:0]       ext_c;
    logic [7:0]        sel_byte_c;
    logic [15:0]       sel_half_c;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word;

    assign req_ready = (state == S_IDLE) && rst;
    assign accept_c  = req_valid && req_ready;

    // The request on the bus drives the datapath while idle; latched fields afterwards.
    assign cur_we    = (state == S_IDLE) ? req_we     : lat_we;
    assign cur_f3    = (state == S_IDLE) ? req_funct3 : lat_f3;
    assign cur_addr  = (state == S_IDLE) ? req_addr   : lat_addr;
    assign cur_wdata = (state == S_IDLE) ? req_wdata  : lat_wdata;

    // Edge entering RESP: array read and store write happen here.
    assign commit_c = rst && (((state == S_IDLE) && accept_c && (WAIT_CYC == 0)) ||
                              ((state == S_BUSY) && (cnt == '0)));

    assign idx_c = IDX_W'(cur_addr[ADDR_W-1:2]);

    // Fault decode: illegal funct3, misalignment, out-of-range address.
    always_comb begin
        logic illegal;
        logic misal;
        logic oor;
        illegal = (cur_f3[1:0] == 2'b11) || (cur_f3 == 3'b110) || (cur_we && cur_f3[2]);
        misal   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                  ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        oor     = ({1'b0, cur_addr} >= ADDR_LIMIT);
        err_c   = illegal || misal || oor;
    end

    // Store lane enables and replicated write data.
    always_comb begin
        be_c = 4'b0000;
        wd_c = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be_c = 4'b0001 << cur_addr[1:0];
                wd_c = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be_c = cur_addr[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{cur_wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = cur_wdata;
            end
        endcase
    end

    // Load extraction from the word read at commit.
    always_comb begin
        sel_byte_c = rd_word[{lat_addr[1:0], 3'b000} +: 8];
        sel_half_c = rd_word[{lat_addr[1], 4'b0000} +: 16];
        ext_c      = '0;
        case (lat_f3)
            3'b000:  ext_c = {{24{sel_byte_c[7]}}, sel_byte_c};
            3'b001:  ext_c = {{16{sel_half_c[15]}}, sel_half_c};
            3'b010:  ext_c = rd_word;
            3'b100:  ext_c = {24'h000000, sel_byte_c};
            3'b101:  ext_c = {16'h0000, sel_half_c};
            default: ext_c = '0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept_c) state_nxt = (WAIT_CYC == 0) ? S_RESP : S_BUSY;
            S_BUSY: if (cnt == '0) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_f3    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept_c) begin
            cnt       <= CNT_INIT;
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end else if ((state == S_BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // RAM array: read-before-write on the commit edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit_c && !err_c) begin
            rd_word <= mem[idx_c];
            if (cur_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_c[i]) mem[idx_c][8*i +: 8] <= wd_c[8*i +: 8];
                end
            end
        end
    end

    // Response registers: one-cycle strobe on leaving RESP, data/err held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == S_RESP) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            rsp_rdata <= (err_c || lat_we) ? 32'h0 : ext_c;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: two instances (WAIT_CYC=0 and 3) driven with directed and
// random requests, checked against a byte-array reference model.
module tb_data_mem_ctrl;

    logic              clk;
    logic [1:0]        rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][2:0]   req_funct3;
    logic [1:0][10:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [1:0][31:0]  rsp_rdata;
    logic [1:0]        rsp_err;

    int n_chk;
    int n_fail;
    logic [7:0] mm [2][1024];
    time last_acc [2];

    data_mem_ctrl #(.ADDR_W(11), .DEPTH(256), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.ADDR_W(11), .DEPTH(256), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    function automatic int wc(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: access legality, then little-endian byte array update / read.
    task automatic model(input int k, input bit we, input logic [2:0] f3, input logic [10:0] addr,
                         input logic [31:0] wd, output bit e_err, output logic [31:0] e_data);
        int size;
        int a;
        bit legal;
        a     = int'(addr);
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
        size  = ((f3 == 3'd0) || (f3 == 3'd4)) ? 1 : ((f3 == 3'd1) || (f3 == 3'd5)) ? 2 : 4;
        e_err = !legal || ((a % size) != 0) || (a >= 1024);
        e_data = 32'h0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mm[k][a+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) e_data[8*i +: 8] = mm[k][a+i];
                if ((f3 < 3'd4) && (size < 4) && e_data[8*size-1]) begin
                    for (int i = size; i < 4; i++) e_data[8*i +: 8] = 8'hFF;
                end
            end
        end
    endtask

    task automatic scramble(input int k);
        req_we[k]     = 1'($urandom);
        req_funct3[k] = 3'($urandom);
        req_addr[k]   = 11'($urandom);
        req_wdata[k]  = $urandom;
    endtask

    // One request: wait for ready, accept, then check latency, ready-low window and response.
    task automatic do_req(input int k, input bit we, input logic [2:0] f3, input logic [10:0] addr,
                          input logic [31:0] wd, input bit hold, output logic [31:0] got);
        bit e_err;
        logic [31:0] e_data;
        int lat;
        int low;
        int n;
        time t;
        got = 32'h0;
        @(negedge clk);
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            chk("ready_timeout", 32'(req_ready[k]), 32'd1);
            req_valid[k] = 1'b0;
            return;
        end
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_funct3[k] = f3;
        req_addr[k]   = addr;
        req_wdata[k]  = wd;
        model(k, we, f3, addr, wd, e_err, e_data);
        @(posedge clk);
        t = $time;
        if (hold && last_acc[k] != 0) chk("spacing", 32'((t - last_acc[k]) / 10), 32'(wc(k) + 2));
        last_acc[k] = t;
        #1;
        req_valid[k] = hold;
        scramble(k);
        lat = 0;
        low = 0;
        while (!rsp_valid[k] && lat < 20) begin
            if (!req_ready[k]) low++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(wc(k) + 1));
        chk("ready_low", 32'(low), 32'(wc(k) + 1));
        chk("rdata", rsp_rdata[k], e_data);
        chk("err", 32'(rsp_err[k]), 32'(e_err));
        got = rsp_rdata[k];
        if (!hold) begin
            @(posedge clk);
            #1;
            chk("pulse", 32'(rsp_valid[k]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] exp;
        logic [10:0] a;
        int cnt;
        n_chk = 0;
        n_fail = 0;
        last_acc[0] = 0;
        last_acc[1] = 0;
        rst = 2'b00;
        req_valid = 2'b00;
        for (int k = 0; k < 2; k++) scramble(k);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(req_ready[k]), 32'd0);
            chk("rst_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rdata", rsp_rdata[k], 32'd0);
            chk("rst_err", 32'(rsp_err[k]), 32'd0);
        end
        @(negedge clk);
        rst = 2'b11;

        // Fill both arrays so the model knows every byte.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 256; w++) do_req(k, 1'b1, 3'd2, 11'(w * 4), $urandom, 1'b0, got);

        // Word store/load, byte store and extensions, faults.
        do_req(0, 1'b1, 3'd2, 11'h010, 32'hDEADBEEF, 1'b0, got);
        do_req(0, 1'b0, 3'd2, 11'h010, 32'h0, 1'b0, got);
        chk("t1_lw", got, 32'hDEADBEEF);
        do_req(0, 1'b1, 3'd0, 11'h013, 32'h00000080, 1'b0, got);
        do_req(0, 1'b0, 3'd0, 11'h013, 32'h0, 1'b0, got);
        chk("t2_lb", got, 32'hFFFFFF80);
        do_req(0, 1'b0, 3'd4, 11'h013, 32'h0, 1'b0, got);
        chk("t2_lbu", got, 32'h00000080);
        do_req(0, 1'b0, 3'd2, 11'h010, 32'h0, 1'b0, got);
        chk("t2_lw", got, 32'h80ADBEEF);
        do_req(0, 1'b1, 3'd1, 11'h011, 32'h0000FFFF, 1'b0, got);
        do_req(0, 1'b0, 3'd2, 11'h012, 32'h0, 1'b0, got);
        do_req(0, 1'b0, 3'd2, 11'h010, 32'h0, 1'b0, got);
        chk("t3_unchanged", got, 32'h80ADBEEF);
        do_req(0, 1'b0, 3'd3, 11'h010, 32'h0, 1'b0, got);
        do_req(0, 1'b1, 3'd4, 11'h010, 32'h0, 1'b0, got);
        do_req(0, 1'b0, 3'd2, 11'h400, 32'h0, 1'b0, got);
        do_req(1, 1'b0, 3'd2, 11'h400, 32'h0, 1'b0, got);
        do_req(1, 1'b0, 3'd5, 11'h3FE, 32'h0, 1'b0, got);

        // Reset during BUSY aborts the store and its response.
        exp = {mm[1][35], mm[1][34], mm[1][33], mm[1][32]};
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1] = 1'b1;
        req_funct3[1] = 3'd2;
        req_addr[1] = 11'h020;
        req_wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("t5_ready_in_rst", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1]) cnt++;
        end
        chk("t5_no_rsp", 32'(cnt), 32'd0);
        chk("t5_rdata_rst", rsp_rdata[1], 32'd0);
        do_req(1, 1'b0, 3'd2, 11'h020, 32'h0, 1'b0, got);
        chk("t5_prior", got, exp);

        // Back-to-back stream with req_valid held high.
        for (int k = 0; k < 2; k++) begin
            last_acc[k] = 0;
            for (int i = 0; i < 12; i++) begin
                a = 11'($urandom_range(0, 255) * 4);
                do_req(k, 1'b1, 3'd2, a, $urandom, 1'b1, got);
                do_req(k, 1'b0, 3'd2, a, 32'h0, 1'b1, got);
            end
            req_valid[k] = 1'b0;
            last_acc[k] = 0;
        end

        // Random traffic.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) a = 11'($urandom);
                else a = 11'($urandom_range(0, 1023));
                if ($urandom_range(0, 1) == 1) a = a & 11'h7FC;
                do_req(k, 1'($urandom), 3'($urandom), a, $urandom, 1'b0, got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
